// File: rtl/kore_pkg.sv
// kore_pkg: shared encodings for the kore execution stage.
// The optional multiply unit is enabled with the KORE_FUNC_MUL_EN macro.
package kore_pkg;

   // func8 operation codes
   localparam logic [7:0] FN_ADD = 8'h00;
   localparam logic [7:0] FN_SUB = 8'h01;
   localparam logic [7:0] FN_AND = 8'h02;
   localparam logic [7:0] FN_OR  = 8'h03;
   localparam logic [7:0] FN_XOR = 8'h04;
   localparam logic [7:0] FN_SLL = 8'h05;
   localparam logic [7:0] FN_SRL = 8'h06;
   localparam logic [7:0] FN_MUL = 8'h07;

   localparam logic [6:0] OPC_ALU = 7'b0110011;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      MUL,
      WB,
      HOLD
   } func_state_t;

   // An op is legal only with the ALU opcode and a known func8 code.
   function automatic logic is_legal(input logic [6:0] opc, input logic [7:0] fn,
                                     input logic mul_en);
      return (opc == OPC_ALU) && ((fn <= FN_SRL) || (mul_en && (fn == FN_MUL)));
   endfunction

endpackage

// File: rtl/kore_regfile.sv
// kore_regfile: 32 x DATA_W register file, x0 hardwired to zero.
// Two combinational operand reads, one combinational debug read, one synchronous write.
module kore_regfile #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [4:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [4:0]        raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o,
   input  logic [4:0]        raddr_dbg_i,
   output logic [DATA_W-1:0] rdata_dbg_o
);

   logic [DATA_W-1:0] mem_q [32];

   // Storage: cleared on reset, writes to x0 dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != 5'd0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read ports: x0 always returns zero.
   always_comb begin
      rdata_a_o   = (raddr_a_i == 5'd0) ? '0 : mem_q[raddr_a_i];
      rdata_b_o   = (raddr_b_i == 5'd0) ? '0 : mem_q[raddr_b_i];
      rdata_dbg_o = (raddr_dbg_i == 5'd0) ? '0 : mem_q[raddr_dbg_i];
   end

endmodule

// File: rtl/kore_funcfsm.sv
// kore_funcfsm: execution stage behind the operation FSM. Starts on a rising opflag,
// executes one ALU op (or an iterative multiply), writes back and pulses eop.
// Macro KORE_FUNC_MUL_EN adds the shift-add multiplier; without it func8 0x07 is illegal.
module kore_funcfsm
   import kore_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              opflag,
   input  logic [6:0]        opcode,
   input  logic [7:0]        pc_sel,
   input  logic [4:0]        pcdata_rs0,
   input  logic [4:0]        pcdata_rs1,
   input  logic [4:0]        pcdata_rd,
   input  logic [4:0]        dbg_addr,
   output logic              eop,
   output logic              err,
   output logic              busy,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int unsigned SH_W = $clog2(DATA_W);
`ifdef KORE_FUNC_MUL_EN
   localparam logic MUL_EN = 1'b1;
   localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);
`else
   localparam logic MUL_EN = 1'b0;
`endif

   func_state_t       state_q, state_d;
   logic              opflag_q;
   logic [7:0]        func_q, func_d;
   logic              legal_q, legal_d;
   logic [4:0]        rd_q, rd_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] result_q, result_d;
`ifdef KORE_FUNC_MUL_EN
   logic [DATA_W-1:0] acc_q, acc_d, acc_sum;
   logic [SH_W-1:0]   cnt_q, cnt_d;
`endif

   logic              start;
   logic [DATA_W-1:0] rf_a, rf_b;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] wb_data;
   logic              wb_en;

   assign start   = opflag & ~opflag_q;
   assign wb_data = result_q;
   assign wb_en   = (state_q == WB) && legal_q && (rd_q != 5'd0);

   kore_regfile #(
      .DATA_W (DATA_W)
   ) u_rf (
      .clk         (clk),
      .rst_n       (rst_n),
      .we_i        (wb_en),
      .waddr_i     (rd_q),
      .wdata_i     (wb_data),
      .raddr_a_i   (pcdata_rs0),
      .rdata_a_o   (rf_a),
      .raddr_b_i   (pcdata_rs1),
      .rdata_b_o   (rf_b),
      .raddr_dbg_i (dbg_addr),
      .rdata_dbg_o (dbg_data)
   );

   // Single-cycle ALU on the latched operands; illegal ops yield zero.
   always_comb begin
      alu_res = '0;
      if (legal_q) begin
         unique case (func_q)
            FN_ADD:  alu_res = a_q + b_q;
            FN_SUB:  alu_res = a_q - b_q;
            FN_AND:  alu_res = a_q & b_q;
            FN_OR:   alu_res = a_q | b_q;
            FN_XOR:  alu_res = a_q ^ b_q;
            FN_SLL:  alu_res = a_q << b_q[SH_W-1:0];
            FN_SRL:  alu_res = a_q >> b_q[SH_W-1:0];
            default: alu_res = '0;
         endcase
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d  = state_q;
      func_d   = func_q;
      legal_d  = legal_q;
      rd_d     = rd_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
`ifdef KORE_FUNC_MUL_EN
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      acc_sum  = acc_q + (b_q[0] ? a_q : '0);
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               func_d  = pc_sel;
               legal_d = is_legal(opcode, pc_sel, MUL_EN);
               rd_d    = pcdata_rd;
               a_d     = rf_a;
               b_d     = rf_b;
               state_d = EXEC;
            end
         end
         EXEC: begin
`ifdef KORE_FUNC_MUL_EN
            if (legal_q && (func_q == FN_MUL)) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL;
            end else begin
               result_d = alu_res;
               state_d  = WB;
            end
`else
            result_d = alu_res;
            state_d  = WB;
`endif
         end
`ifdef KORE_FUNC_MUL_EN
         // One multiplier bit per cycle: A shifts left, B shifts right.
         MUL: begin
            acc_d = acc_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               result_d = acc_sum;
               state_d  = WB;
            end
         end
`endif
         WB: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (!opflag) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         opflag_q <= 1'b0;
         func_q   <= '0;
         legal_q  <= 1'b0;
         rd_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
`ifdef KORE_FUNC_MUL_EN
         acc_q    <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         opflag_q <= opflag;
         func_q   <= func_d;
         legal_q  <= legal_d;
         rd_q     <= rd_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
`ifdef KORE_FUNC_MUL_EN
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

   // Outputs decoded from state; eop lasts exactly the WB cycle.
   always_comb begin
      eop    = (state_q == WB);
      err    = (state_q == WB) && !legal_q;
      busy   = (state_q != IDLE);
      result = result_q;
   end

endmodule

// File: tb/tb_kore_funcfsm.sv
// tb_kore_funcfsm: directed self-checking bench for kore_funcfsm.
// Honors KORE_FUNC_MUL_EN to pick the expected multiply behaviour.
module tb_kore_funcfsm;
   import kore_pkg::*;

   localparam int unsigned DATA_W = 32;
`ifdef KORE_FUNC_MUL_EN
   localparam int MUL_LAT = DATA_W + 1;
`endif

   logic              clk;
   logic              rst_n;
   logic              opflag;
   logic [6:0]        opcode;
   logic [7:0]        pc_sel;
   logic [4:0]        pcdata_rs0, pcdata_rs1, pcdata_rd, dbg_addr;
   logic              eop, err, busy;
   logic [DATA_W-1:0] result, dbg_data;

   int n_chk  = 0;
   int n_fail = 0;

   kore_funcfsm #(
      .DATA_W (DATA_W)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opflag     (opflag),
      .opcode     (opcode),
      .pc_sel     (pc_sel),
      .pcdata_rs0 (pcdata_rs0),
      .pcdata_rs1 (pcdata_rs1),
      .pcdata_rd  (pcdata_rd),
      .dbg_addr   (dbg_addr),
      .eop        (eop),
      .err        (err),
      .busy       (busy),
      .result     (result),
      .dbg_data   (dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic rf_chk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
      dbg_addr = idx;
      #1;
      check(tag, dbg_data, exp);
   endtask

   // Issue one op, measure eop latency in edges after the start edge, then retire it.
   task automatic run_op(input string tag, input logic [6:0] opc, input logic [7:0] fn,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] d,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_res,
                         input int hold_cyc, input bit drop_early);
      int  k;
      int  extra;
      bit  got;
      @(negedge clk);
      opcode = opc; pc_sel = fn; pcdata_rs0 = s0; pcdata_rs1 = s1; pcdata_rd = d;
      opflag = 1'b1;
      @(posedge clk);
      #1;
      // Fields scrambled after the start edge must not matter.
      opcode = ~opc; pc_sel = fn ^ 8'h01; pcdata_rs0 = ~s0; pcdata_rs1 = ~s1; pcdata_rd = ~d;
      if (drop_early) opflag = 1'b0;
      k = 0;
      got = 1'b0;
      while (!got && k < 100) begin
         @(posedge clk);
         #1;
         k++;
         if (eop) got = 1'b1;
      end
      check({tag, "_lat"}, k, exp_lat);
      check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      check({tag, "_res"}, result, exp_res);
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check({tag, "_eop_len"}, {31'd0, eop}, 32'd0);
      if (hold_cyc > 0) begin
         extra = 0;
         for (int i = 0; i < hold_cyc; i++) begin
            @(posedge clk);
            #1;
            if (eop) extra++;
         end
         check({tag, "_no_restart"}, extra, 0);
         check({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
      end
      @(negedge clk);
      opflag = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   // Writes val into rf[idx] by overriding the write-back data of an x0+x0 ADD.
   task automatic load_reg(input logic [4:0] idx, input logic [31:0] val);
      force u_dut.wb_data = val;
      run_op("load", OPC_ALU, FN_ADD, 5'd0, 5'd0, idx, 1, 1'b0, 32'd0, 0, 1'b0);
      release u_dut.wb_data;
      rf_chk("load_rf", idx, val);
   endtask

   initial begin
      int n_eop;
      rst_n = 1'b0; opflag = 1'b0; opcode = '0; pc_sel = '0;
      pcdata_rs0 = '0; pcdata_rs1 = '0; pcdata_rd = '0; dbg_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_eop", {31'd0, eop}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", result, 32'd0);
      for (int i = 0; i < 32; i++) rf_chk("rst_rf", 5'(i), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD 5 + 3
      load_reg(5'd1, 32'd5);
      load_reg(5'd2, 32'd3);
      run_op("add", OPC_ALU, FN_ADD, 5'd1, 5'd2, 5'd3, 1, 1'b0, 32'd8, 0, 1'b0);
      rf_chk("add_rf", 5'd3, 32'd8);

      // SUB 0 - 1 wraps; opflag drops during EXEC
      load_reg(5'd1, 32'd0);
      load_reg(5'd2, 32'd1);
      run_op("sub", OPC_ALU, FN_SUB, 5'd1, 5'd2, 5'd4, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b1);
      rf_chk("sub_rf", 5'd4, 32'hFFFF_FFFF);
      run_op("addwrap", OPC_ALU, FN_ADD, 5'd4, 5'd2, 5'd7, 1, 1'b0, 32'd0, 0, 1'b0);
      rf_chk("addwrap_rf", 5'd7, 32'd0);

      // SLL uses only the low shift-amount bits of B
      load_reg(5'd1, 32'd1);
      load_reg(5'd2, 32'd35);
      run_op("sll35", OPC_ALU, FN_SLL, 5'd1, 5'd2, 5'd6, 1, 1'b0, 32'd8, 0, 1'b0);
      rf_chk("sll35_rf", 5'd6, 32'd8);

      // Logic and logical shifts
      load_reg(5'd1, 32'hF0F0_1234);
      load_reg(5'd2, 32'h0FF0_0004);
      run_op("and", OPC_ALU, FN_AND, 5'd1, 5'd2, 5'd8, 1, 1'b0, 32'h00F0_0004, 0, 1'b0);
      run_op("or", OPC_ALU, FN_OR, 5'd1, 5'd2, 5'd9, 1, 1'b0, 32'hFFF0_1234, 0, 1'b0);
      run_op("xor", OPC_ALU, FN_XOR, 5'd1, 5'd2, 5'd10, 1, 1'b0, 32'hFF00_1230, 0, 1'b0);
      run_op("srl", OPC_ALU, FN_SRL, 5'd1, 5'd2, 5'd11, 1, 1'b0, 32'h0F0F_0123, 0, 1'b0);
      run_op("sll", OPC_ALU, FN_SLL, 5'd1, 5'd2, 5'd12, 1, 1'b0, 32'h0F01_2340, 0, 1'b0);
      rf_chk("xor_rf", 5'd10, 32'hFF00_1230);
      rf_chk("srl_rf", 5'd11, 32'h0F0F_0123);

      // MUL 7 * 6
      load_reg(5'd1, 32'd7);
      load_reg(5'd2, 32'd6);
`ifdef KORE_FUNC_MUL_EN
      run_op("mul", OPC_ALU, FN_MUL, 5'd1, 5'd2, 5'd5, MUL_LAT, 1'b0, 32'd42, 0, 1'b0);
      rf_chk("mul_rf", 5'd5, 32'd42);
`else
      run_op("mul_off", OPC_ALU, FN_MUL, 5'd1, 5'd2, 5'd5, 1, 1'b1, 32'd0, 0, 1'b0);
      rf_chk("mul_off_rf", 5'd5, 32'd0);
`endif

      // Illegal opcode and func8: no write-back
      run_op("bad_opc", 7'h13, FN_ADD, 5'd1, 5'd2, 5'd1, 1, 1'b1, 32'd0, 0, 1'b0);
      rf_chk("bad_opc_rf", 5'd1, 32'd7);
      run_op("bad_fn", OPC_ALU, 8'h20, 5'd1, 5'd2, 5'd2, 1, 1'b1, 32'd0, 0, 1'b0);
      rf_chk("bad_fn_rf", 5'd2, 32'd6);

      // rd = 0 discards the write
      run_op("rd0", OPC_ALU, FN_ADD, 5'd1, 5'd2, 5'd0, 1, 1'b0, 32'd13, 0, 1'b0);
      rf_chk("rd0_rf", 5'd0, 32'd0);

      // Sources equal to rd read pre-write values; opflag held high 10 cycles after eop
      run_op("self", OPC_ALU, FN_ADD, 5'd1, 5'd1, 5'd1, 1, 1'b0, 32'd14, 10, 1'b0);
      rf_chk("self_rf", 5'd1, 32'd14);

      // Reset in the middle of an operation
      @(negedge clk);
      opcode = OPC_ALU; pcdata_rs0 = 5'd1; pcdata_rs1 = 5'd2; pcdata_rd = 5'd13;
`ifdef KORE_FUNC_MUL_EN
      pc_sel = FN_MUL;
`else
      pc_sel = FN_ADD;
`endif
      opflag = 1'b1;
      @(posedge clk);
      #1;
      n_eop = 0;
`ifdef KORE_FUNC_MUL_EN
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (eop) n_eop++;
      end
`endif
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_err", {31'd0, err}, 32'd0);
      rf_chk("mid_rst_rf1", 5'd1, 32'd0);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (eop) n_eop++;
      end
      check("mid_rst_no_eop", n_eop, 0);
      rf_chk("mid_rst_rf13", 5'd13, 32'd0);
      @(negedge clk);
      opflag = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_busy", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
